// File: rtl/led_cmd_pkg.sv
// led_cmd_pkg: opcodes, FSM encoding and LED count shared by the LED command driver.
package led_cmd_pkg;

    localparam int LED_N = 4;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_OFF    = 3'b001;
    localparam logic [2:0] OP_ON     = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_BLINK  = 3'b100;
    localparam logic [2:0] OP_SWEEP  = 3'b101;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler producing a one-cycle tick every TICK_DIV clocks; clr restarts the count.
module led_tick_gen #(
    parameter logic [31:0] TICK_DIV = 32'd50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    logic [31:0] r_cnt;

    assign tick = r_cnt == TICK_DIV - 32'd1;

    always_ff @(posedge clk) begin
        if (rst || clr)
            r_cnt <= '0;
        else
            r_cnt <= tick ? '0 : r_cnt + 32'd1;
    end

endmodule

// File: rtl/led_cmd_driver.sv
// led_cmd_driver: command-driven set/clear/toggle/blink/sweep driver for four active-low LEDs.
// Optional output dimming is enabled by defining LED_PWM_DIM_EN.
module led_cmd_driver
    import led_cmd_pkg::*;
#(
    parameter logic [31:0] TICK_DIV = 32'd50_000_000,
    parameter int          DIM_DUTY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [LED_N-1:0] cmd_mask,
    output logic             cmd_err,
    output logic [LED_N-1:0] led_out
);

    logic [LED_N-1:0] r_on;
    logic [LED_N-1:0] r_blink;
    logic             r_phase;
    logic [0:0]       r_state;
    logic [1:0]       r_step;
    logic             r_err;
    logic             w_tick;
    logic             w_acc;
    logic             w_sweep_go;
    logic             w_clr_blink;
    logic [LED_N-1:0] w_on_nxt;
    logic [LED_N-1:0] w_blink_nxt;
    logic [LED_N-1:0] w_lit;
    logic [LED_N-1:0] w_lit_out;

    assign cmd_ready  = r_state == ST_IDLE;
    assign w_acc      = cmd_valid && cmd_ready;
    assign w_sweep_go = w_acc && cmd_op == OP_SWEEP;

    // Restarting the prescaler on sweep entry makes every sweep step a full TICK_DIV cycles.
    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_sweep_go),
        .tick (w_tick)
    );

    always_comb begin
        w_clr_blink = cmd_op == OP_OFF || cmd_op == OP_ON || cmd_op == OP_TOGGLE;
        w_on_nxt    = cmd_op == OP_OFF    ? r_on & ~cmd_mask :
                      cmd_op == OP_ON     ? r_on | cmd_mask  :
                      cmd_op == OP_TOGGLE ? r_on ^ cmd_mask  : r_on;
        w_blink_nxt = cmd_op == OP_BLINK  ? r_blink | cmd_mask  :
                      w_clr_blink         ? r_blink & ~cmd_mask : r_blink;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_on    <= '0;
            r_blink <= '0;
            r_phase <= 1'b0;
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_acc && cmd_op[2:1] == 2'b11;
            if (w_tick)
                r_phase <= ~r_phase;
            if (w_acc) begin
                r_on    <= w_on_nxt;
                r_blink <= w_blink_nxt;
            end
            if (w_sweep_go) begin
                r_state <= ST_SWEEP;
                r_step  <= '0;
            end else if (r_state == ST_SWEEP && w_tick) begin
                r_step <= r_step + 2'd1;
                if (r_step == 2'd3)
                    r_state <= ST_IDLE;
            end
        end
    end

    // Blinking LEDs follow the shared phase; on_r is kept so it reappears when blink is cleared.
    assign w_lit = r_state == ST_SWEEP ? LED_N'(1) << r_step
                                       : (r_blink & {LED_N{r_phase}}) | (~r_blink & r_on);

`ifdef LED_PWM_DIM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge clk) begin
        if (rst)
            r_pwm <= '0;
        else
            r_pwm <= r_pwm + 4'd1;
    end

    assign w_lit_out = (int'(r_pwm) < DIM_DUTY) ? w_lit : '0;
`else
    logic w_unused_dim;

    assign w_unused_dim = ^DIM_DUTY;
    assign w_lit_out    = w_lit;
`endif

    assign led_out = ~w_lit_out;
    assign cmd_err = r_err;

endmodule

// File: tb/tb_led_cmd_driver.sv
// tb_led_cmd_driver: directed scoreboard bench for led_cmd_driver with TICK_DIV=4.
module tb_led_cmd_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'b000;
    logic [3:0] cmd_mask = 4'b0000;
    logic       cmd_ready;
    logic       cmd_err;
    logic [3:0] led_out;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [3:0] led;
        logic       rdy;
        logic       err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    led_cmd_driver #(.TICK_DIV(32'd4), .DIM_DUTY(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_err   (cmd_err),
        .led_out   (led_out)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push(string tag, logic [3:0] led, logic rdy, logic err);
        sb.push_back('{tag, led, rdy, err});
    endtask

    task automatic step();
        exp_t e;
        cyc();
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_led"}, 32'(led_out), 32'(e.led));
            chk({e.tag, "_rdy"}, 32'(cmd_ready), 32'(e.rdy));
            chk({e.tag, "_err"}, 32'(cmd_err), 32'(e.err));
        end
    endtask

    task automatic send(logic [2:0] op, logic [3:0] mask);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
    endtask

    initial begin
        logic [3:0] s[17];
        int         tr[$];
        int         lows;
        // Reset held for three cycles
        rst = 1'b1;
        repeat (3) begin
            push("reset", 4'b1111, 1'b1, 1'b0);
            step();
        end
        rst = 1'b0;
        // ON then TOGGLE, each visible one cycle after its accept
        send(3'b010, 4'b0101);
        push("on_0101", 4'b1010, 1'b1, 1'b0);
        step();
        send(3'b011, 4'b0011);
        push("toggle_0011", 4'b1001, 1'b1, 1'b0);
        step();
        cmd_valid = 1'b0;
        push("hold", 4'b1001, 1'b1, 1'b0);
        step();
        // mask=0 accepted as a no-op
        send(3'b010, 4'b0000);
        push("mask0", 4'b1001, 1'b1, 1'b0);
        step();
        // BLINK LED3: pin alternates every 4 cycles, other pins steady
        send(3'b100, 4'b1000);
        cyc();
        cmd_valid = 1'b0;
        s[0] = led_out;
        for (int i = 1; i < 17; i++) begin
            cyc();
            s[i] = led_out;
        end
        for (int i = 0; i < 17; i++) begin
            if (i % 4 == 0)
                chk("blink_low3", 32'(s[i][2:0]), 32'(3'b001));
            if (i > 0 && s[i][3] != s[i-1][3])
                tr.push_back(i);
        end
        chk("blink_edges", 32'(tr.size()), 32'd4);
        for (int i = 1; i < tr.size(); i++)
            chk("blink_period", 32'(tr[i] - tr[i-1]), 32'd4);
        // ON LED3 stops blink
        send(3'b010, 4'b1000);
        push("on_1000", 4'b0001, 1'b1, 1'b0);
        step();
        cmd_valid = 1'b0;
        repeat (8) begin
            push("steady3", 4'b0001, 1'b1, 1'b0);
            step();
        end
        // SWEEP with all on, OFF held during the sweep
        send(3'b010, 4'b1111);
        push("on_all", 4'b0000, 1'b1, 1'b0);
        step();
        send(3'b101, 4'b0000);
        for (int k = 0; k < 4; k++)
            repeat (4) push("sweep", ~(4'b0001 << k), 1'b0, 1'b0);
        step();
        send(3'b001, 4'b1111);
        repeat (15) step();
        push("sweep_end", 4'b0000, 1'b1, 1'b0);
        step();
        push("held_off", 4'b1111, 1'b1, 1'b0);
        step();
        cmd_valid = 1'b0;
        // Reserved opcodes pulse cmd_err without touching LEDs
        send(3'b010, 4'b0011);
        push("on_0011", 4'b1100, 1'b1, 1'b0);
        step();
        send(3'b110, 4'b1111);
        push("op110", 4'b1100, 1'b1, 1'b1);
        step();
        cmd_valid = 1'b0;
        push("op110_after", 4'b1100, 1'b1, 1'b0);
        step();
        send(3'b111, 4'b0101);
        push("op111", 4'b1100, 1'b1, 1'b1);
        step();
        cmd_valid = 1'b0;
        push("op111_after", 4'b1100, 1'b1, 1'b0);
        step();
        // Reset in sweep step 2
        send(3'b101, 4'b1111);
        repeat (4) push("rsweep0", 4'b1110, 1'b0, 1'b0);
        repeat (4) push("rsweep1", 4'b1101, 1'b0, 1'b0);
        push("rsweep2", 4'b1011, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        push("mid_rst", 4'b1111, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        push("post_rst", 4'b1111, 1'b1, 1'b0);
        step();
`ifdef LED_PWM_DIM_EN
        send(3'b010, 4'b1111);
        cyc();
        cmd_valid = 1'b0;
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (led_out == 4'b0000)
                lows++;
            else
                chk("pwm_off", 32'(led_out), 32'(4'b1111));
        end
        chk("pwm_duty", 32'(lows), 32'd8);
`else
        lows = 0;
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
